// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: FSM encoding and default sizing for the
// stock keeper and the product-status LED block, so both agree on CNT_W.
package vm_pkg;

    localparam int unsigned DEF_NUM_PROD   = 4;
    localparam int unsigned DEF_CNT_W      = 4;
    localparam int unsigned DEF_MAX_STOCK  = 9;
    localparam int unsigned DEF_INIT_STOCK = 5;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPENSE = 1'b1
    } state_t;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter with a zero flag; used for motor-on time and change-return timing.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        load load_val (takes priority over en)
//   en          decrement by one (holds at zero)
//   load_val    value loaded on load
//   zero_c      combinational flag: counter currently holds zero
module dispense_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] value;

    // Down-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero_c = (value == '0);

endmodule

// File: rtl/prod_stock_ctrl.sv
// Per-product stock keeper and dispense sequencer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   prod_sel            selected product index
//   dispense_req        request level (rising edge accepted once)
//   restock             one-cycle pulse: add one unit to prod_sel (IDLE only, saturating)
//   prod_count_current  registered stock of the displayed product (1-cycle latency)
//   motor_en            dispense motor drive, high DISP_CYCLES cycles per dispense
//   busy                high while dispensing
//   dispense_done       one-cycle pulse at end of dispense
//   dispense_nack       one-cycle pulse when a request hits a sold-out product
module prod_stock_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned NUM_PROD    = DEF_NUM_PROD,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MAX_STOCK   = DEF_MAX_STOCK,
    parameter int unsigned INIT_STOCK  = DEF_INIT_STOCK,
    parameter int unsigned DISP_CYCLES = 10_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_PROD)-1:0] prod_sel,
    input  logic                        dispense_req,
    input  logic                        restock,
    output logic [CNT_W-1:0]            prod_count_current,
    output logic                        motor_en,
    output logic                        busy,
    output logic                        dispense_done,
    output logic                        dispense_nack
);

    localparam int unsigned SEL_W = $clog2(NUM_PROD);
    // A 1-cycle dispense still needs a 1-bit timer
    localparam int unsigned TMR_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DISP_CYCLES - 1);

    state_t             state, state_next;
    logic               req_q;
    logic               req_rise_c;
    logic [SEL_W-1:0]   sel_q, sel_q_next;
    logic [CNT_W-1:0]   count [NUM_PROD];

    logic               tmr_load, tmr_en, tmr_zero_c;
    logic               cnt_we;
    logic [SEL_W-1:0]   cnt_idx;
    logic [CNT_W-1:0]   cnt_wdata;
    logic               motor_next, done_next, nack_next;
    logic [CNT_W-1:0]   pcc_next;

    assign req_rise_c = dispense_req & ~req_q;

    dispense_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TMR_LOAD),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, count write port and output decode
    always_comb begin
        state_next = state;
        sel_q_next = sel_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        cnt_we     = 1'b0;
        cnt_idx    = prod_sel;
        cnt_wdata  = count[prod_sel];
        done_next  = 1'b0;
        nack_next  = 1'b0;
        pcc_next   = count[prod_sel];

        case (state)
            ST_IDLE: begin
                if (req_rise_c) begin
                    // Request wins over a coincident restock
                    sel_q_next = prod_sel;
                    if (count[prod_sel] == '0) begin
                        nack_next = 1'b1;
                    end else begin
                        state_next = ST_DISPENSE;
                        tmr_load   = 1'b1;
                    end
                end else if (restock) begin
                    cnt_we = 1'b1;
                    if (count[prod_sel] < CNT_W'(MAX_STOCK)) begin
                        cnt_wdata = count[prod_sel] + CNT_W'(1);
                    end
                end
            end
            ST_DISPENSE: begin
                pcc_next = count[sel_q];
                if (tmr_zero_c) begin
                    cnt_we     = 1'b1;
                    cnt_idx    = sel_q;
                    cnt_wdata  = count[sel_q] - CNT_W'(1);
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        motor_next = (state_next == ST_DISPENSE);
    end

    // State, stock array and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            req_q              <= 1'b0;
            sel_q              <= '0;
            for (int unsigned i = 0; i < NUM_PROD; i++) begin
                count[i] <= CNT_W'(INIT_STOCK);
            end
            motor_en           <= 1'b0;
            busy               <= 1'b0;
            dispense_done      <= 1'b0;
            dispense_nack      <= 1'b0;
            prod_count_current <= CNT_W'(INIT_STOCK);
        end else begin
            state              <= state_next;
            req_q              <= dispense_req;
            sel_q              <= sel_q_next;
            if (cnt_we) begin
                count[cnt_idx] <= cnt_wdata;
            end
            motor_en           <= motor_next;
            busy               <= motor_next;
            dispense_done      <= done_next;
            dispense_nack      <= nack_next;
            prod_count_current <= pcc_next;
        end
    end

endmodule

// File: tb/tb_prod_stock_ctrl.sv
// Bench for prod_stock_ctrl with a 4-cycle dispense: directed vector table,
// hand-written corner sequences and a random run checked against a stock/dispense model.
module tb_prod_stock_ctrl;

    localparam int unsigned DISP = 4;
    localparam int unsigned NP   = 4;
    localparam int unsigned MAXS = 9;
    localparam int unsigned INIT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] prod_sel;
    logic       dispense_req;
    logic       restock;
    logic [3:0] prod_count_current;
    logic       motor_en, busy, dispense_done, dispense_nack;

    int n_chk  = 0;
    int n_fail = 0;

    prod_stock_ctrl #(.DISP_CYCLES(DISP)) dut (
        .clk                (clk),
        .rst                (rst),
        .prod_sel           (prod_sel),
        .dispense_req       (dispense_req),
        .restock            (restock),
        .prod_count_current (prod_count_current),
        .motor_en           (motor_en),
        .busy               (busy),
        .dispense_done      (dispense_done),
        .dispense_nack      (dispense_nack)
    );

    always #5 clk = ~clk;

    // Reference model: stock per product, cycles of motor time remaining
    int stk [NP];
    int left_cyc;
    int lat_sel;
    bit prev_req;
    int e_motor, e_busy, e_done, e_nack, e_pcc;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input int s, input bit q, input bit rs);
        int pcc_n;
        bit rise;
        if (r) begin
            foreach (stk[i]) stk[i] = INIT;
            left_cyc = 0; prev_req = 0; lat_sel = 0;
            e_motor = 0; e_busy = 0; e_done = 0; e_nack = 0; e_pcc = INIT;
            return;
        end
        rise   = q && !prev_req;
        e_done = 0;
        e_nack = 0;
        pcc_n  = (left_cyc == 0) ? stk[s] : stk[lat_sel];
        if (left_cyc == 0) begin
            if (rise) begin
                lat_sel = s;
                if (stk[s] == 0) e_nack = 1;
                else left_cyc = DISP;
            end else if (rs) begin
                stk[s] = (stk[s] + 1 > MAXS) ? MAXS : stk[s] + 1;
            end
        end else begin
            left_cyc--;
            if (left_cyc == 0) begin
                stk[lat_sel]--;
                e_done = 1;
            end
        end
        e_motor  = (left_cyc > 0);
        e_busy   = e_motor;
        prev_req = q;
        e_pcc    = pcc_n;
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input bit r, input int s, input bit q, input bit rs);
        rst = r; prod_sel = 2'(s); dispense_req = q; restock = rs;
        @(posedge clk);
        model(r, s, q, rs);
        @(negedge clk);
        chk("motor_en", int'(motor_en), e_motor);
        chk("busy", int'(busy), e_busy);
        chk("dispense_done", int'(dispense_done), e_done);
        chk("dispense_nack", int'(dispense_nack), e_nack);
        chk("prod_count_current", int'(prod_count_current), e_pcc);
    endtask

    task automatic disp(input int s);
        step(0, s, 1, 0);
        repeat (DISP + 1) step(0, s, 0, 0);
    endtask

    typedef struct {
        bit r; int s; bit q; bit rs;
        int m; int b; int d; int n; int pcc;
    } vec_t;

    vec_t tbl [8];
    int   done_cnt;

    initial begin
        // rst sel req rs | motor busy done nack pcc
        tbl[0] = '{1, 2, 0, 0, 0, 0, 0, 0, 5};
        tbl[1] = '{0, 2, 0, 0, 0, 0, 0, 0, 5};
        tbl[2] = '{0, 1, 1, 0, 1, 1, 0, 0, 5};
        tbl[3] = '{0, 1, 1, 0, 1, 1, 0, 0, 5};
        tbl[4] = '{0, 1, 1, 0, 1, 1, 0, 0, 5};
        tbl[5] = '{0, 1, 1, 0, 1, 1, 0, 0, 5};
        tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 0, 5};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 0, 4};

        rst = 1'b1; prod_sel = '0; dispense_req = 1'b0; restock = 1'b0;
        @(negedge clk);

        // Reset state and first dispense of product 1
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].q, tbl[i].rs);
            chk($sformatf("vec%0d motor", i), int'(motor_en), tbl[i].m);
            chk($sformatf("vec%0d busy", i), int'(busy), tbl[i].b);
            chk($sformatf("vec%0d done", i), int'(dispense_done), tbl[i].d);
            chk($sformatf("vec%0d nack", i), int'(dispense_nack), tbl[i].n);
            chk($sformatf("vec%0d pcc", i), int'(prod_count_current), tbl[i].pcc);
        end

        // Sell out product 0, then the sixth request is refused
        repeat (5) disp(0);
        step(0, 0, 1, 0);
        chk("soldout nack", int'(dispense_nack), 1);
        chk("soldout motor", int'(motor_en), 0);
        step(0, 0, 0, 0);
        chk("soldout nack pulse", int'(dispense_nack), 0);
        chk("soldout count", int'(prod_count_current), 0);

        // Restock product 3 past the ceiling
        repeat (6) begin
            step(0, 3, 0, 1);
            step(0, 3, 0, 0);
        end
        step(0, 3, 0, 0);
        chk("restock saturate", int'(prod_count_current), 9);

        // Restock coincident with a request: only the dispense lands
        step(0, 3, 1, 1);
        chk("req beats restock motor", int'(motor_en), 1);
        repeat (DISP + 1) step(0, 3, 0, 0);
        chk("req beats restock count", int'(prod_count_current), 8);

        // Held request dispenses once; sel change mid-dispense is ignored
        done_cnt = 0;
        step(0, 2, 1, 0);
        for (int i = 0; i < 19; i++) begin
            step(0, 1, 1, 0);
            if (dispense_done) done_cnt++;
        end
        chk("held req single dispense", done_cnt, 1);
        step(0, 2, 0, 0);
        step(0, 2, 0, 0);
        chk("latched product decremented", int'(prod_count_current), 4);
        step(0, 1, 0, 0);
        chk("other product untouched", int'(prod_count_current), 4);

        // Reset on the second motor cycle
        step(0, 3, 1, 0);
        step(0, 3, 0, 0);
        step(1, 3, 0, 0);
        chk("reset stops motor", int'(motor_en), 0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, k, 0, 0);
            if (dispense_done) done_cnt++;
            step(0, k, 0, 0);
            if (dispense_done) done_cnt++;
            chk($sformatf("reset count%0d", k), int'(prod_count_current), 5);
        end
        chk("no done after reset", done_cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0));
            chk("done/nack exclusive", int'(dispense_done & dispense_nack), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
